// File: rtl/svm_det_fifo.sv
// Detection collector behind the SVM classifier: thresholds each slide-window score,
// converts the window index to grid row/column, buffers hits in a circular FIFO with a
// valid/ready head, and reports per-frame hit/drop totals on the last window of a frame.
module svm_det_fifo #(
   parameter int unsigned SW_W    = 11,
   parameter int unsigned SCORE_W = 24,
   parameter int unsigned COL_N   = 39,
   parameter int unsigned MAX_SW  = 1130,
   parameter int unsigned DEPTH   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   input  logic [SW_W-1:0]    i_sw_id,
   input  logic [SCORE_W-1:0] i_score,
   input  logic [SCORE_W-1:0] i_thresh,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [4:0]         o_row,
   output logic [5:0]         o_col,
   output logic [SCORE_W-1:0] o_score,
   output logic               o_frame_done,
   output logic [SW_W-1:0]    o_det_cnt,
   output logic [SW_W-1:0]    o_drop_cnt,
   output logic               o_ovf
);

   localparam int unsigned     PtrW   = $clog2(DEPTH);
   localparam int unsigned     EntW   = 5 + 6 + SCORE_W;
   localparam logic [SW_W-1:0] LastSw = SW_W'(MAX_SW);
   localparam logic [SW_W-1:0] ColN   = SW_W'(COL_N);

   // Stage 1 registers
   logic               s1_valid_q, s1_valid_d;
   logic [SW_W-1:0]    s1_sw_id_q;
   logic [SCORE_W-1:0] s1_score_q;
   logic [SCORE_W-1:0] s1_thresh_q;

   // FIFO state
   logic [EntW-1:0]    mem_q [DEPTH];
   logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
   logic [EntW-1:0]    head;

   // Frame counters and status
   logic [SW_W-1:0]    det_cnt_q, det_cnt_d;
   logic [SW_W-1:0]    drop_cnt_q, drop_cnt_d;
   logic [SW_W-1:0]    det_out_q, det_out_d;
   logic [SW_W-1:0]    drop_out_q, drop_out_d;
   logic [SW_W-1:0]    det_sum, drop_sum;
   logic               frame_done_q, frame_done_d;
   logic               ovf_q, ovf_d;

   // Stage 2 decode
   logic               hit, frame_end;
   logic               full, empty, push, pop, drop;
   logic [4:0]         row;
   logic [5:0]         col;

   // Out-of-range window indices are dropped before they ever reach stage 2.
   assign s1_valid_d = i_valid && (i_sw_id <= LastSw);

   assign hit       = s1_valid_q && ($signed(s1_score_q) > $signed(s1_thresh_q));
   assign frame_end = s1_valid_q && (s1_sw_id_q == LastSw);
   assign row       = 5'(s1_sw_id_q / ColN);
   assign col       = 6'(s1_sw_id_q % ColN);

   // Extra MSB on the pointers distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                  (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign pop   = !empty && i_ready;
   // A full FIFO still accepts a hit when the head leaves in the same cycle.
   assign push  = hit && (!full || pop);
   assign drop  = hit && !push;

   assign head = mem_q[rd_ptr_q[PtrW-1:0]];

   // Head outputs are forced to zero while empty so they read 0 after reset.
   always_comb begin
      o_valid = !empty;
      o_row   = '0;
      o_col   = '0;
      o_score = '0;
      if (!empty) begin
         {o_row, o_col, o_score} = head;
      end
   end

   assign o_frame_done = frame_done_q;
   assign o_det_cnt    = det_out_q;
   assign o_drop_cnt   = drop_out_q;
   assign o_ovf        = ovf_q;

   // Next-state for pointers, frame counters and sticky overflow.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      det_sum      = det_cnt_q + SW_W'(hit);
      drop_sum     = drop_cnt_q + SW_W'(drop);
      det_cnt_d    = det_sum;
      drop_cnt_d   = drop_sum;
      det_out_d    = det_out_q;
      drop_out_d   = drop_out_q;
      frame_done_d = frame_end;
      ovf_d        = ovf_q || drop;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Totals include the final window itself; running counts restart for the next frame.
      if (frame_end) begin
         det_out_d  = det_sum;
         drop_out_d = drop_sum;
         det_cnt_d  = '0;
         drop_cnt_d = '0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q   <= 1'b0;
         s1_sw_id_q   <= '0;
         s1_score_q   <= '0;
         s1_thresh_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         det_cnt_q    <= '0;
         drop_cnt_q   <= '0;
         det_out_q    <= '0;
         drop_out_q   <= '0;
         frame_done_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_sw_id_q   <= i_sw_id;
         s1_score_q   <= i_score;
         s1_thresh_q  <= i_thresh;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         det_cnt_q    <= det_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         det_out_q    <= det_out_d;
         drop_out_q   <= drop_out_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
      end
   end

   // Storage array; contents are only observed through the pointers, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PtrW-1:0]] <= {row, col, s1_score_q};
      end
   end

endmodule

// File: tb/tb_svm_det_fifo.sv
// Self-checking bench for svm_det_fifo: a behavioural queue model is fed from the input
// stimulus at each rising edge and compared against the DUT head/status on falling edges,
// plus directed checks for the scenarios of interest.
module tb_svm_det_fifo;

   localparam int SW_W    = 11;
   localparam int SCORE_W = 24;
   localparam int COL_N   = 39;
   localparam int MAX_SW  = 1130;
   localparam int DEPTH   = 16;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      i_valid;
   logic [SW_W-1:0]           i_sw_id;
   logic signed [SCORE_W-1:0] i_score;
   logic signed [SCORE_W-1:0] i_thresh;
   logic                      i_ready;
   logic                      o_valid;
   logic [4:0]                o_row;
   logic [5:0]                o_col;
   logic [SCORE_W-1:0]        o_score;
   logic                      o_frame_done;
   logic [SW_W-1:0]           o_det_cnt;
   logic [SW_W-1:0]           o_drop_cnt;
   logic                      o_ovf;

   svm_det_fifo #(
      .SW_W   (SW_W),
      .SCORE_W(SCORE_W),
      .COL_N  (COL_N),
      .MAX_SW (MAX_SW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .i_sw_id     (i_sw_id),
      .i_score     (i_score),
      .i_thresh    (i_thresh),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_row       (o_row),
      .o_col       (o_col),
      .o_score     (o_score),
      .o_frame_done(o_frame_done),
      .o_det_cnt   (o_det_cnt),
      .o_drop_cnt  (o_drop_cnt),
      .o_ovf       (o_ovf)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, $signed(got), $signed(exp),
                  $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      int row;
      int col;
      int score;
   } ent_t;

   ent_t exp_q[$];
   bit   m_v;
   int   m_id, m_score, m_thr;
   int   m_det, m_drop, m_det_out, m_drop_out;
   bit   m_fd, m_ovf;

   task automatic model_clear();
      exp_q.delete();
      m_v = 0; m_id = 0; m_score = 0; m_thr = 0;
      m_det = 0; m_drop = 0; m_det_out = 0; m_drop_out = 0;
      m_fd = 0; m_ovf = 0;
   endtask

   task automatic model_step();
      bit   pop, hit, push, drop, last;
      ent_t e;
      pop  = (exp_q.size() != 0) && i_ready;
      hit  = m_v && (m_score > m_thr);
      push = hit && ((exp_q.size() < DEPTH) || pop);
      drop = hit && !push;
      if (pop) void'(exp_q.pop_front());
      if (push) begin
         e.row   = m_id / COL_N;
         e.col   = m_id % COL_N;
         e.score = m_score;
         exp_q.push_back(e);
      end
      if (hit) m_det++;
      if (drop) begin
         m_drop++;
         m_ovf = 1;
      end
      last = m_v && (m_id == MAX_SW);
      m_fd = last;
      if (last) begin
         m_det_out  = m_det;
         m_drop_out = m_drop;
         m_det      = 0;
         m_drop     = 0;
      end
      m_v     = i_valid && (int'(i_sw_id) <= MAX_SW);
      m_id    = int'(i_sw_id);
      m_score = int'(i_score);
      m_thr   = int'(i_thresh);
   endtask

   task automatic check_step();
      chk("sb_valid", 32'(o_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("sb_row", 32'(o_row), exp_q[0].row);
         chk("sb_col", 32'(o_col), exp_q[0].col);
         chk("sb_score", 32'($signed(o_score)), exp_q[0].score);
      end
      chk("sb_frame_done", 32'(o_frame_done), 32'(m_fd));
      chk("sb_det_cnt", 32'(o_det_cnt), m_det_out);
      chk("sb_drop_cnt", 32'(o_drop_cnt), m_drop_out);
      chk("sb_ovf", 32'(o_ovf), 32'(m_ovf));
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk);
         if (rst) model_step();
      end
   end

   initial forever begin
      @(negedge rst);
      model_clear();
   end

   initial forever begin
      @(negedge clk);
      check_step();
   end

   // ---------------- stimulus helpers ----------------
   // Values set here are sampled by the DUT at the following rising edge.
   task automatic drive(input logic v, input int id, input int sc, input logic rdy);
      @(posedge clk);
      #2;
      i_valid = v;
      i_sw_id = SW_W'(id);
      i_score = SCORE_W'(sc);
      i_ready = rdy;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int k = 0; k < n; k++) drive(1'b0, 0, 0, rdy);
   endtask

   // Last window as a non-hit, then check the one-cycle frame report.
   task automatic end_frame(input int det, input int drp, input logic rdy);
      drive(1'b1, MAX_SW, -1000, rdy);
      idle(2, rdy);
      @(negedge clk);
      chk("frame_done_pulse", 32'(o_frame_done), 1);
      chk("frame_det_cnt", 32'(o_det_cnt), det);
      chk("frame_drop_cnt", 32'(o_drop_cnt), drp);
      idle(1, rdy);
      @(negedge clk);
      chk("frame_done_clear", 32'(o_frame_done), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      i_valid  = 1'b0;
      i_sw_id  = '0;
      i_score  = '0;
      i_thresh = '0;
      i_ready  = 1'b0;
      #1 rst = 1'b0;
      #2;
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_row", 32'(o_row), 0);
      chk("rst_col", 32'(o_col), 0);
      chk("rst_score", 32'(o_score), 0);
      chk("rst_det", 32'(o_det_cnt), 0);
      chk("rst_drop", 32'(o_drop_cnt), 0);
      chk("rst_ovf", 32'(o_ovf), 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;

      // Single hit: 545 -> row 13, col 38; a score equal to the threshold is not a hit.
      i_thresh = 0;
      drive(1'b1, 545, 100, 1'b0);
      drive(1'b1, 546, 0, 1'b0);
      @(negedge clk);
      chk("single_latency", 32'(o_valid), 0);
      idle(1, 1'b0);
      @(negedge clk);
      chk("single_valid", 32'(o_valid), 1);
      chk("single_row", 32'(o_row), 13);
      chk("single_col", 32'(o_col), 38);
      chk("single_score", 32'($signed(o_score)), 100);
      idle(1, 1'b1);
      idle(1, 1'b0);
      @(negedge clk);
      chk("single_only_one", 32'(o_valid), 0);

      // Negative threshold: only -49 exceeds -50.
      i_thresh = -50;
      drive(1'b1, 600, -49, 1'b0);
      drive(1'b1, 601, -50, 1'b0);
      drive(1'b1, 602, -51, 1'b0);
      idle(2, 1'b0);
      @(negedge clk);
      chk("neg_valid", 32'(o_valid), 1);
      chk("neg_row", 32'(o_row), 15);
      chk("neg_col", 32'(o_col), 15);
      chk("neg_score", 32'($signed(o_score)), -49);
      idle(1, 1'b1);
      idle(1, 1'b0);
      @(negedge clk);
      chk("neg_only_one", 32'(o_valid), 0);
      end_frame(2, 0, 1'b0);

      // Frame boundary: three hits then a non-hit final window; next frame is empty.
      i_thresh = 0;
      drive(1'b1, 10, 5, 1'b1);
      drive(1'b1, 20, 5, 1'b1);
      drive(1'b1, 30, 5, 1'b1);
      end_frame(3, 0, 1'b1);
      drive(1'b1, 1131, 500, 1'b1);
      idle(2, 1'b1);
      @(negedge clk);
      chk("ignore_1131", 32'(o_valid), 0);
      end_frame(0, 0, 1'b1);

      // Overflow: 20 hits into 16 slots with the consumer stalled.
      for (int id = 1111; id <= 1130; id++) drive(1'b1, id, id - 1110, 1'b0);
      idle(2, 1'b0);
      @(negedge clk);
      chk("ovf_frame_done", 32'(o_frame_done), 1);
      chk("ovf_det_cnt", 32'(o_det_cnt), 20);
      chk("ovf_drop_cnt", 32'(o_drop_cnt), 4);
      chk("ovf_flag", 32'(o_ovf), 1);
      chk("ovf_head_row", 32'(o_row), 28);
      chk("ovf_head_col", 32'(o_col), 19);
      idle(15, 1'b1);
      idle(1, 1'b0);
      @(negedge clk);
      chk("ovf_last_row", 32'(o_row), 28);
      chk("ovf_last_col", 32'(o_col), 34);
      idle(1, 1'b1);
      idle(1, 1'b0);
      @(negedge clk);
      chk("ovf_drained", 32'(o_valid), 0);
      chk("ovf_sticky", 32'(o_ovf), 1);

      // Full with a pop in the same cycle as a push: no drop, still full afterwards.
      for (int id = 0; id < DEPTH; id++) drive(1'b1, id, 9, 1'b0);
      drive(1'b1, 40, 3, 1'b0);
      idle(1, 1'b1);
      idle(1, 1'b0);
      end_frame(DEPTH + 1, 0, 1'b0);
      drive(1'b1, 41, 3, 1'b0);
      end_frame(1, 1, 1'b0);
      idle(DEPTH + 2, 1'b1);
      @(negedge clk);
      chk("full_drained", 32'(o_valid), 0);

      // Asynchronous reset between edges with five entries queued.
      for (int id = 100; id < 105; id++) drive(1'b1, id, 1, 1'b0);
      idle(2, 1'b0);
      @(negedge clk);
      chk("pre_rst_valid", 32'(o_valid), 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_valid", 32'(o_valid), 0);
      chk("arst_det", 32'(o_det_cnt), 0);
      chk("arst_drop", 32'(o_drop_cnt), 0);
      chk("arst_ovf", 32'(o_ovf), 0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      drive(1'b1, 200, 1, 1'b0);
      idle(2, 1'b0);
      @(negedge clk);
      chk("post_rst_valid", 32'(o_valid), 1);
      chk("post_rst_row", 32'(o_row), 5);
      chk("post_rst_col", 32'(o_col), 5);
      idle(1, 1'b1);
      idle(1, 1'b0);
      @(negedge clk);
      chk("post_rst_alone", 32'(o_valid), 0);
      end_frame(1, 0, 1'b0);

      idle(2, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
